// File: rtl/stream_muxn_if.sv
// Handshake bundle for stream_muxn: N producer channels in, one registered stream out.
// master is the environment side (producers + consumer), slave is the mux.
interface stream_muxn_if #(
    parameter int BITWIDTH = 32,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = 2
);
    logic                         mode;
    logic [SEL_W-1:0]             sel;
    logic [CHANNELS-1:0]          in_valid;
    logic [CHANNELS*BITWIDTH-1:0] in_data;
    logic [CHANNELS-1:0]          in_ready;
    logic                         out_valid;
    logic [BITWIDTH-1:0]          out_data;
    logic [SEL_W-1:0]             out_chan;
    logic                         out_ready;

    modport master (
        output mode, sel, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_chan
    );

    modport slave (
        input  mode, sel, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_chan
    );
endinterface

// File: rtl/stream_muxn.sv
// N-channel valid/ready stream mux with a single registered output stage.
// Fixed-select or round-robin arbitration; one transfer per cycle sustained.
module stream_muxn #(
    parameter int BITWIDTH = 32,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    stream_muxn_if.slave bus
);
    logic                load_en;
    logic                xfer;
    logic                grant_vld;
    logic [SEL_W-1:0]    grant;
    logic [SEL_W-1:0]    ptr;
    logic                sel_in_range;
    logic                sel_valid;
    logic                hi_vld;
    logic                lo_vld;
    logic [SEL_W-1:0]    hi_idx;
    logic [SEL_W-1:0]    lo_idx;
    logic [BITWIDTH-1:0] mux_data;

    assign load_en      = rst_n & (~bus.out_valid | bus.out_ready);
    assign sel_in_range = {1'b0, bus.sel} < (SEL_W+1)'(CHANNELS);

    // Descending scan: the last hit is the lowest index. hi_* covers ptr..CHANNELS-1,
    // lo_* covers the whole range and is the wrapped fallback.
    always_comb begin
        sel_valid = 1'b0;
        hi_vld    = 1'b0;
        lo_vld    = 1'b0;
        hi_idx    = '0;
        lo_idx    = '0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (bus.sel == SEL_W'(i)) sel_valid = bus.in_valid[i];
            if (bus.in_valid[i]) begin
                lo_vld = 1'b1;
                lo_idx = SEL_W'(i);
                if (SEL_W'(i) >= ptr) begin
                    hi_vld = 1'b1;
                    hi_idx = SEL_W'(i);
                end
            end
        end
    end

    always_comb begin
        if (bus.mode) begin
            grant_vld = hi_vld | lo_vld;
            grant     = hi_vld ? hi_idx : lo_idx;
        end else begin
            grant_vld = sel_in_range & sel_valid;
            grant     = bus.sel;
        end
    end

    assign xfer = load_en & grant_vld;

    // Fixed-mode ready follows sel alone so a channel never sees its neighbours' valids.
    always_comb begin
        bus.in_ready = '0;
        mux_data     = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (grant == SEL_W'(i)) mux_data = bus.in_data[i*BITWIDTH +: BITWIDTH];
            if (bus.mode)
                bus.in_ready[i] = load_en & grant_vld & (grant == SEL_W'(i));
            else
                bus.in_ready[i] = load_en & (bus.sel == SEL_W'(i));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_chan  <= '0;
            ptr           <= '0;
        end else if (xfer) begin
            bus.out_valid <= 1'b1;
            bus.out_data  <= mux_data;
            bus.out_chan  <= grant;
            if (bus.mode)
                ptr <= (grant == SEL_W'(CHANNELS - 1)) ? '0 : grant + SEL_W'(1);
        end else if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
        end
    end
endmodule
